// File: rtl/ifetch_unit_if.sv
// ----------------------------------------------------------------------------
// ifetch_unit_if
//   Bundles the instruction-memory request/response channel and the
//   decode-side instruction queue handshake of the fetch unit.
//
//   master : the fetch unit (drives imem request, presents instructions)
//   slave  : memory + decode environment (acks, returns data, consumes,
//            redirects)
//
//   imem_req     fetch request to instruction memory
//   imem_addr    word-aligned fetch address
//   imem_ack     memory accepts the request this cycle
//   imem_rvalid  response data valid this cycle
//   imem_rdata   instruction word
//   inst_valid   queue head holds an instruction
//   inst         queue head instruction
//   inst_pc      PC of the queue head
//   inst_ready   decode consumes the head
//   redirect     branch/jump taken
//   redirect_pc  new fetch target
// ----------------------------------------------------------------------------
interface ifetch_unit_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_ready;
    logic        redirect;
    logic [31:0] redirect_pc;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_rvalid,
        input  imem_rdata,
        output inst_valid,
        output inst,
        output inst_pc,
        input  inst_ready,
        input  redirect,
        input  redirect_pc
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_rvalid,
        output imem_rdata,
        input  inst_valid,
        input  inst,
        input  inst_pc,
        output inst_ready,
        output redirect,
        output redirect_pc
    );
endinterface

// File: rtl/ifetch_unit.sv
// ----------------------------------------------------------------------------
// ifetch_unit
//   Instruction fetch unit: issues one word fetch at a time to instruction
//   memory, pushes returned words with their fetch address into a small
//   instruction queue, and presents the queue head to decode.
//
//   Parameters
//     RESET_PC  first fetch address after reset
//     DEPTH     instruction queue entries (power of two, 2..8)
//
//   Ports
//     clk_i     clock, all state on rising edge
//     rst_ni    asynchronous active-low reset
//     bus       ifetch_unit_if.master (imem request/response, inst queue,
//               redirect)
//
//   Build option
//     IFU_REDIRECT_EN  when defined, redirect/redirect_pc flush the queue,
//                      retarget fetch and drop the in-flight response.
//                      When undefined both inputs are ignored.
//
//   State   | meaning
//   --------+-------------------------------------------------------------
//   S_IDLE  | no request active; waits for a free queue slot
//   S_REQ   | imem_req high with a stable address, waiting for imem_ack
//   S_WAIT  | request accepted, waiting for imem_rvalid
// ----------------------------------------------------------------------------
module ifetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000,
    parameter int          DEPTH    = 2
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    ifetch_unit_if.master bus
);

    localparam int             PW      = $clog2(DEPTH);
    localparam int             CW      = PW + 1;
    localparam logic [CW-1:0]  DEPTH_C = CW'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [31:0]     fetch_pc_q, fetch_pc_d;
    logic [31:0]     addr_q, addr_d;
    logic            discard_q, discard_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;

    logic [31:0]     data_mem [DEPTH];
    logic [31:0]     pc_mem   [DEPTH];

    logic            redir;
    logic [31:0]     redir_pc;
    logic            rsp_take;
    logic            push;
    logic            pop;
    logic [CW-1:0]   free_slots;

`ifdef IFU_REDIRECT_EN
    assign redir    = bus.redirect;
    assign redir_pc = {bus.redirect_pc[31:2], 2'b00};
`else
    assign redir    = 1'b0;
    assign redir_pc = '0;
`endif

    // The slot reserved by an in-flight request counts as used.
    assign free_slots = DEPTH_C - count_q - {{(CW-1){1'b0}}, (state_q == S_WAIT)};

    // ------------------------------------------------------------------
    // Queue bookkeeping
    // ------------------------------------------------------------------
    always_comb begin
        rsp_take = (state_q == S_WAIT) && bus.imem_rvalid;
        // A response is dropped if it belongs to a redirected-away fetch,
        // or if a redirect lands on the very cycle it returns.
        push     = rsp_take && !discard_q && !redir;
        // A redirect flushes the queue, so a same-cycle pop is void.
        pop      = (count_q != '0) && bus.inst_ready && !redir;

        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;

        if (redir) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
            if (push && !pop) begin
                count_d = count_q + CW'(1);
            end else if (!push && pop) begin
                count_d = count_q - CW'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Fetch FSM next state
    // ------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        addr_d     = addr_q;
        discard_d  = discard_q;

        case (state_q)
            S_IDLE: begin
                if (free_slots != '0) state_d = S_REQ;
            end
            S_REQ: begin
                if (bus.imem_ack) state_d = S_WAIT;
            end
            S_WAIT: begin
                if (bus.imem_rvalid) begin
                    discard_d = 1'b0;
                    // Go straight back to REQ when the queue still has room
                    // after this cycle's push/pop: one word per two cycles.
                    state_d   = (count_d < DEPTH_C) ? S_REQ : S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (push) fetch_pc_d = fetch_pc_q + 32'd4;

        if (redir) begin
            fetch_pc_d = redir_pc;
            // Mark the outstanding transaction stale. A response arriving in
            // this same cycle is already dropped above, so nothing remains.
            if (state_q == S_REQ || (state_q == S_WAIT && !bus.imem_rvalid)) begin
                discard_d = 1'b1;
            end
        end

        // The request address is captured only on entry to REQ, so a
        // redirect while waiting for ack keeps presenting the old address.
        if (state_d == S_REQ && state_q != S_REQ) addr_d = fetch_pc_d;
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= S_IDLE;
            fetch_pc_q <= RESET_PC;
            addr_q     <= RESET_PC;
            discard_q  <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            addr_q     <= addr_d;
            discard_q  <= discard_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
        end
    end

    // Queue storage needs no reset: an entry is only visible once counted.
    always_ff @(posedge clk_i) begin
        if (push) begin
            data_mem[wr_ptr_q] <= bus.imem_rdata;
            pc_mem[wr_ptr_q]   <= addr_q;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.imem_req   = (state_q == S_REQ);
    assign bus.imem_addr  = addr_q;
    assign bus.inst_valid = (count_q != '0);
    assign bus.inst       = bus.inst_valid ? data_mem[rd_ptr_q] : 32'd0;
    assign bus.inst_pc    = bus.inst_valid ? pc_mem[rd_ptr_q]   : 32'd0;

endmodule

// File: tb/tb_ifetch_unit.sv
module tb_ifetch_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_3000;
    localparam int          DEPTH    = 2;

    logic clk;
    logic rst_n;

    ifetch_unit_if bus ();

    ifetch_unit #(
        .RESET_PC (RESET_PC),
        .DEPTH    (DEPTH)
    ) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: expected instruction stream as (pc, word) pairs,
    // the next sequential fetch address, and the single in-flight fetch.
    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
    } ent_t;

    ent_t        mq[$];
    logic [31:0] exp_pc;
    bit          outstanding;
    logic [31:0] out_addr;
    bit          drop;
    bit          stale;
    logic [31:0] stale_addr;
    bit          prev_hold;
    logic [31:0] prev_addr;
    int          npush;

    int          ack_prob;
    int          rv_prob;
    int          rdy_prob;
    int          spur_prob;
    int          redir_prob;
    bit          redir_next;
    logic [31:0] redir_target;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic clear_model();
        mq.delete();
        exp_pc      = RESET_PC;
        outstanding = 0;
        drop        = 0;
        stale       = 0;
        prev_hold   = 0;
        npush       = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n           = 1'b0;
        bus.imem_ack    = 1'b1;
        bus.imem_rvalid = 1'b1;
        bus.imem_rdata  = 32'hDEAD_BEEF;
        bus.inst_ready  = 1'b1;
        bus.redirect    = 1'b0;
        @(negedge clk);
        chk("rst_req",   {31'd0, bus.imem_req},   32'd0);
        chk("rst_valid", {31'd0, bus.inst_valid}, 32'd0);
        chk("rst_inst",  bus.inst,                32'd0);
        chk("rst_pc",    bus.inst_pc,             32'd0);
        chk("rst_addr",  bus.imem_addr,           RESET_PC);
        @(negedge clk);
        clear_model();
        // Released with rvalid still high: the unit is idle and must ignore it.
        rst_n = 1'b1;
    endtask

    task automatic run_cycles(input int n);
        for (int c = 0; c < n; c++) begin
            logic        req_s, ack_s, rv_s, rdy_s, red_s, red_eff, had;
            logic [31:0] addr_s, rdata_s, red_pc_s;
            @(negedge clk);
            req_s  = bus.imem_req;
            addr_s = bus.imem_addr;

            chk("inst_valid", {31'd0, bus.inst_valid}, {31'd0, (mq.size() != 0)});
            if (mq.size() != 0) begin
                chk("inst",    bus.inst,    mq[0].inst);
                chk("inst_pc", bus.inst_pc, mq[0].pc);
            end
            chk("addr_align", {30'd0, addr_s[1:0]}, 32'd0);
            if (outstanding) chk("req_in_wait", {31'd0, req_s}, 32'd0);
            if (req_s) begin
                chk("req_addr", addr_s, stale ? stale_addr : exp_pc);
                chk("req_room", {31'd0, (mq.size() < DEPTH)}, 32'd1);
            end
            if (prev_hold) begin
                chk("hold_req",  {31'd0, req_s}, 32'd1);
                chk("hold_addr", addr_s, prev_addr);
            end

            ack_s   = ($urandom_range(99) < ack_prob);
            rv_s    = outstanding ? ($urandom_range(99) < rv_prob)
                                  : ($urandom_range(99) < spur_prob);
            rdata_s = $urandom;
            rdy_s   = ($urandom_range(99) < rdy_prob);
            if (redir_next) begin
                red_s      = 1'b1;
                red_pc_s   = redir_target;
                redir_next = 0;
            end else begin
                red_s    = ($urandom_range(99) < redir_prob);
                red_pc_s = $urandom;
            end
            bus.imem_ack    = ack_s;
            bus.imem_rvalid = rv_s;
            bus.imem_rdata  = rdata_s;
            bus.inst_ready  = rdy_s;
            bus.redirect    = red_s;
            bus.redirect_pc = red_pc_s;

`ifdef IFU_REDIRECT_EN
            red_eff = red_s;
`else
            red_eff = 1'b0;
`endif
            // Effect of the coming rising edge.
            had = (mq.size() != 0);
            if (outstanding && rv_s) begin
                if (!drop && !red_eff) begin
                    mq.push_back('{pc: out_addr, inst: rdata_s});
                    exp_pc = exp_pc + 32'd4;
                    npush++;
                end
                outstanding = 0;
                drop        = 0;
            end
            if (had && rdy_s && !red_eff) void'(mq.pop_front());
            if (req_s && ack_s) begin
                outstanding = 1;
                out_addr    = addr_s;
                drop        = stale;
                stale       = 0;
            end
            if (red_eff) begin
                mq.delete();
                exp_pc = {red_pc_s[31:2], 2'b00};
                if (outstanding) begin
                    drop = 1;
                end else if (req_s) begin
                    stale      = 1;
                    stale_addr = addr_s;
                end
            end
            prev_hold = req_s && !ack_s;
            prev_addr = addr_s;
        end
    endtask

    task automatic wait_req(input string tag);
        bit seen;
        seen = 0;
        for (int i = 0; i < 12 && !seen; i++) begin
            run_cycles(1);
            seen = bus.imem_req;
        end
        chk(tag, {31'd0, seen}, 32'd1);
    endtask

    task automatic set_policy(input int a, input int r, input int d, input int s, input int x);
        ack_prob   = a;
        rv_prob    = r;
        rdy_prob   = d;
        spur_prob  = s;
        redir_prob = x;
    endtask

    initial begin
        rst_n           = 1'b0;
        bus.imem_ack    = 1'b0;
        bus.imem_rvalid = 1'b0;
        bus.imem_rdata  = 32'd0;
        bus.inst_ready  = 1'b0;
        bus.redirect    = 1'b0;
        bus.redirect_pc = 32'd0;
        redir_next      = 0;
        redir_target    = 32'd0;
        clear_model();
        set_policy(100, 100, 100, 0, 0);

        // Streaming: ack always, rvalid one cycle later -> one word per 2 cycles.
        do_reset();
        set_policy(100, 100, 100, 0, 0);
        run_cycles(20);
        chk("stream_rate", npush, 32'd10);

        // Decode stalled: queue fills to DEPTH, fetch stops, head stable.
        do_reset();
        set_policy(100, 100, 0, 0, 0);
        run_cycles(12);
        chk("full_valid", {31'd0, bus.inst_valid}, 32'd1);
        chk("full_head",  bus.inst_pc,             RESET_PC);
        chk("full_noreq", {31'd0, bus.imem_req},   32'd0);
        rdy_prob = 100;
        wait_req("resume_seen");
        chk("resume_addr", bus.imem_addr, RESET_PC + 32'd8);
        run_cycles(6);

        // Memory withholds ack: request and address held.
        do_reset();
        set_policy(0, 100, 100, 0, 0);
        run_cycles(6);
        chk("noack_req",  {31'd0, bus.imem_req}, 32'd1);
        chk("noack_addr", bus.imem_addr,         RESET_PC);
        ack_prob = 100;
        run_cycles(6);

        // Reset while waiting for data; late rvalid ignored.
        do_reset();
        set_policy(100, 0, 100, 0, 0);
        run_cycles(3);
        do_reset();
        set_policy(100, 0, 100, 100, 0);
        run_cycles(1);
        chk("rstwait_req",   {31'd0, bus.imem_req},   32'd1);
        chk("rstwait_addr",  bus.imem_addr,           RESET_PC);
        chk("rstwait_valid", {31'd0, bus.inst_valid}, 32'd0);
        set_policy(100, 100, 100, 100, 0);
        run_cycles(8);

`ifdef IFU_REDIRECT_EN
        // Redirect while waiting for data: response dropped, fetch at 4000.
        do_reset();
        set_policy(100, 0, 100, 0, 0);
        run_cycles(3);
        redir_target = 32'h0000_4002;
        redir_next   = 1;
        run_cycles(1);
        rv_prob = 100;
        wait_req("redir_seen");
        chk("redir_addr",  bus.imem_addr,           32'h0000_4000);
        chk("redir_valid", {31'd0, bus.inst_valid}, 32'd0);
        run_cycles(6);

        // Address wrap at the top of the space.
        do_reset();
        set_policy(100, 100, 100, 0, 0);
        redir_target = 32'hFFFF_FFFE;
        redir_next   = 1;
        run_cycles(1);
        wait_req("wrap_seen0");
        chk("wrap_addr0", bus.imem_addr, 32'hFFFF_FFFC);
        run_cycles(1);
        wait_req("wrap_seen1");
        chk("wrap_addr1", bus.imem_addr, 32'h0000_0000);
        run_cycles(6);
`endif

        // Randomised traffic; redirect is also randomised and must be
        // ignored entirely unless the redirect feature is built in.
        do_reset();
        set_policy(60, 50, 50, 30, 5);
        run_cycles(800);
        set_policy(90, 90, 20, 10, 2);
        run_cycles(400);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ifetch_unit.md
IFETCH_UNIT -- requirements
Module: ifetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_3000, SHALL be the first fetch address after reset.
REQ-002 Parameter DEPTH, default 2, SHALL set the instruction queue entry count; legal values are powers of two from 2 to 8.
REQ-003 Ports SHALL be: clock input 1 (all state on rising edge).
REQ-004 reset input 1: asynchronous, active-low.
REQ-005 imem_req output 1: fetch request to instruction memory.
REQ-006 imem_addr output 32: word-aligned fetch address.
REQ-007 imem_ack input 1: memory accepts the request this cycle.
REQ-008 imem_rvalid input 1: response data valid this cycle.
REQ-009 imem_rdata input 32: instruction word.
REQ-010 inst_valid output 1: queue head holds an instruction.
REQ-011 inst output 32: queue head instruction.
REQ-012 inst_pc output 32: PC of the queue head.
REQ-013 inst_ready input 1: decode consumes the head.
REQ-014 redirect input 1: branch/jump taken.
REQ-015 redirect_pc input 32: new fetch target.

Function
REQ-016 FSM states SHALL be IDLE, REQ and WAIT.
- IDLE->REQ: free slots exceed zero.
- REQ->WAIT: on imem_ack.
- WAIT->REQ or IDLE: on imem_rvalid, depending on free slots.
REQ-017 At most one request SHALL be outstanding; imem_req is high only in REQ.
REQ-018 imem_addr SHALL stay stable while imem_req=1 and imem_ack=0.
REQ-019 Free slots SHALL equal DEPTH minus occupancy minus 1 if in WAIT; no request is issued when free slots are zero.
REQ-020 On an accepted response, imem_rdata and its fetch address SHALL be pushed to the queue, and fetch_pc SHALL advance by 4 (mod 2^32 wrap).
REQ-021 Pop SHALL occur when inst_valid=1 and inst_ready=1.
- Simultaneous push and pop on a full queue is legal; occupancy is unchanged.
- inst_ready with an empty queue has no effect.
REQ-022 inst and inst_pc SHALL be stable while inst_valid=1 and inst_ready=0.
REQ-023 imem_rvalid outside WAIT SHALL be ignored.
REQ-024 imem_addr[1:0] SHALL always be 2'b00; redirect_pc[1:0] is ignored.
REQ-025 Minimum latency SHALL be: request cycle N, ack in N, rvalid in N+1, inst_valid in N+2.

Reset
REQ-026 While reset=0, the block SHALL be in the following state:
- FSM in IDLE.
- fetch_pc = RESET_PC.
- Queue empty.
- Discard flag clear.
- imem_req=0, inst_valid=0, inst=0, inst_pc=0, imem_addr=RESET_PC.
REQ-027 Reset asserted mid-request SHALL abandon the transaction.
- Any later rvalid is ignored (REQ-023).
- The first request is issued in the first cycle after reset deassertion.

Configuration
REQ-028 With IFU_REDIRECT_EN defined, redirect=1 SHALL, in the same edge:
- Flush the queue; inst_valid=0 the next cycle, and a same-cycle pop is void.
- Load fetch_pc with {redirect_pc[31:2],2'b00}.
- In REQ or WAIT, set the discard flag so the in-flight response is dropped and not pushed.
- In REQ, keep the old address until ack.
REQ-029 Redirect during the drop cycle SHALL leave the discard flag governing the same in-flight response; the newest redirect_pc wins.
REQ-030 Without IFU_REDIRECT_EN, redirect and redirect_pc SHALL be ignored, and ports remain present.

Verification
REQ-031 Reset, with ack always 1 and rvalid one cycle later -> imem_addr 3000, 3004, 3008…; inst_pc matches; one instruction per 2 cycles.
REQ-032 inst_ready=0 with DEPTH=2 -> exactly 2 entries queued, imem_req stays 0, head stable; set ready=1 -> fetch resumes at 3008.
REQ-033 Hold imem_ack=0 for 5 cycles -> imem_req=1 and imem_addr=3000 held constant throughout.
REQ-034 IFU_REDIRECT_EN: redirect=1, redirect_pc=32'h0000_4002 while in WAIT -> returning word dropped, queue flushed, next imem_addr=4000.
REQ-035 Assert reset=0 in WAIT, then rvalid arrives -> ignored; after release first imem_addr=3000, inst_valid=0.
REQ-036 fetch_pc=FFFF_FFFC via redirect -> next request addresses FFFF_FFFC, then 0000_0000.
